padd_mac_acc: RTL



---
 rtl/padd_mac_pkg.sv | 59 +++++
 rtl/padd_mac_coef_rf.sv | 54 +++++
 rtl/padd_mac_acc.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/padd_mac_pkg.sv
// -----------------------------------------------------------------------------
// padd_mac_pkg
// Shared types, default widths and the result-narrowing helper for the
// padd_mac_acc multiply-accumulate block.
//
// Contents:
//   state_t      FSM encoding {IDLE, ACCUM, DRAIN, HOLD}
//   DEF_*        default parameter values for the top level
//   SN_W         working width of sat_narrow (must be >= ACC_W)
//   sat_narrow   arithmetic right shift followed by optional saturation
// -----------------------------------------------------------------------------
package padd_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 18;
  localparam int DEF_COEF_W = 18;
  localparam int DEF_ACC_W  = 48;
  localparam int DEF_OUT_W  = 18;
  localparam int DEF_TAPS   = 8;
  localparam int DEF_SHIFT  = 17;

  // Working width for the narrowing helper; callers sign-extend into it.
  localparam int SN_W = 64;

  // Returns {clip_flag, value}. value is acc >>> shift, clamped to the signed
  // out_w range when sat_en is set. When sat_en is clear the value is returned
  // unclamped and the caller keeps its low out_w bits (two's-complement wrap).
  function automatic logic [SN_W:0] sat_narrow(
    input logic signed [SN_W-1:0] acc,
    input int                     shift,
    input int                     out_w,
    input logic                   sat_en
  );
    logic signed [SN_W-1:0] v_sh;
    logic signed [SN_W-1:0] v_max;
    logic signed [SN_W-1:0] v_min;
    logic        [SN_W:0]   v_res;
    v_sh  = acc >>> shift;
    v_max = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    // -(2^(out_w-1)) is the bitwise complement of 2^(out_w-1)-1.
    v_min = ~v_max;
    v_res = {1'b0, v_sh};
    if (sat_en) begin
      if (v_sh > v_max) begin
        v_res = {1'b1, v_max};
      end else if (v_sh < v_min) begin
        v_res = {1'b1, v_min};
      end
    end
    return v_res;
  endfunction

endpackage

// File: rtl/padd_mac_coef_rf.sv
// -----------------------------------------------------------------------------
// padd_mac_coef_rf
// TAPS x COEF_W coefficient register file: one synchronous write port, one
// combinational read port. Contents clear on reset, so software must reload
// the taps after every reset.
//
// Ports:
//   clk         clock
//   reset       asynchronous active-high reset, clears every entry
//   i_ce        clock enable; a write only lands when it is high
//   i_wr_en     write strobe
//   i_wr_addr   write tap index
//   i_wr_data   write value (signed)
//   i_rd_addr   read tap index
//   o_rd_data   current contents of i_rd_addr (old value during a write)
// -----------------------------------------------------------------------------
module padd_mac_coef_rf #(
  parameter int TAPS   = 8,
  parameter int COEF_W = 18,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_ce,
  input  logic                     i_wr_en,
  input  logic [AW-1:0]            i_wr_addr,
  input  logic signed [COEF_W-1:0] i_wr_data,
  input  logic [AW-1:0]            i_rd_addr,
  output logic signed [COEF_W-1:0] o_rd_data
);

  logic signed [COEF_W-1:0] r_mem [TAPS];
  logic                     w_wr_ok;
  logic                     w_rd_ok;

  // Index range guards only matter when TAPS is not a power of two.
  assign w_wr_ok = (int'(i_wr_addr) < TAPS);
  assign w_rd_ok = (int'(i_rd_addr) < TAPS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_ce && i_wr_en && w_wr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // The read is combinational from the registers, so a same-cycle write to
  // the tap being read is seen by the multiplier only from the next cycle.
  assign o_rd_data = w_rd_ok ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/padd_mac_acc.sv
// -----------------------------------------------------------------------------
// padd_mac_acc
// Multiply-accumulate stage fed by the Gowin_PADD pre-adder output. Each
// accepted sample is multiplied by coefficient[tap]; TAPS products are summed,
// the sum is arithmetically shifted right by SHIFT, narrowed to OUT_W and
// presented on a valid/ready output.
//
// Build option:
//   PADD_MAC_SAT_EN  defined   -> narrowing saturates and the `sat` output
//                                 flags a clipped result.
//                    undefined -> narrowing keeps the low OUT_W bits and
//                                 there is no `sat` port.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ce                    clock enable; low freezes every register
//   din/din_valid/din_ready       sample input handshake
//   coef_wr_en/_addr/_data        coefficient write port (any state)
//   dout/dout_valid/dout_ready    result output handshake
//   busy                  a result is being accumulated
//   sat                   (PADD_MAC_SAT_EN only) result was clipped
//
// Handshakes: a transfer happens on a rising clk edge where ce, valid and
// ready are all high. din_ready depends only on the FSM state, never on
// din_valid. Once dout_valid rises, dout (and sat) stay stable until an edge
// with ce & dout_ready.
//
// Timing: product of sample k is registered at its accept edge and folded
// into the accumulator at the next accept edge; the last product is folded in
// DRAIN, which also registers the result. A minimum result period is TAPS
// accepts + DRAIN + one HOLD cycle with dout_ready high.
// -----------------------------------------------------------------------------
module padd_mac_acc
  import padd_mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic signed [DATA_W-1:0]  din,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic                      coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]   coef_wr_addr,
  input  logic signed [COEF_W-1:0]  coef_wr_data,
  output logic signed [OUT_W-1:0]   dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      busy
`ifdef PADD_MAC_SAT_EN
  ,
  output logic                      sat
`endif
);

  localparam int TAP_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

`ifdef PADD_MAC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  state_t                    r_state;
  state_t                    w_next_state;
  logic [TAP_W-1:0]          r_tap;
  logic signed [PROD_W-1:0]  r_prod;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [OUT_W-1:0]   r_dout;
  logic                      r_dout_valid;

  logic signed [COEF_W-1:0]  w_coef;
  logic                      w_xfer;
  logic                      w_last;
  logic signed [PROD_W-1:0]  w_prod_next;
  logic signed [ACC_W-1:0]   w_acc_sum;
  logic signed [SN_W-1:0]    w_final_ext;
  logic [SN_W:0]             w_scaled;
  logic signed [OUT_W-1:0]   w_dout_next;
  logic                      w_sat_next;
  logic                      w_unused;

  // ---------------------------------------------------------------------------
  // Coefficient storage, read at the current tap index
  // ---------------------------------------------------------------------------
  padd_mac_coef_rf #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W)
  ) u_coef_rf (
    .clk       (clk),
    .reset     (reset),
    .i_ce      (ce),
    .i_wr_en   (coef_wr_en),
    .i_wr_addr (coef_wr_addr),
    .i_wr_data (coef_wr_data),
    .i_rd_addr (r_tap),
    .o_rd_data (w_coef)
  );

  // ---------------------------------------------------------------------------
  // Datapath combinational terms
  // ---------------------------------------------------------------------------
  assign w_xfer = ce & din_valid & din_ready;
  assign w_last = (r_tap == TAP_W'(TAPS - 1));

  // Both operands sign-extended to the full product width first, so the
  // multiply is full precision.
  assign w_prod_next = PROD_W'(din) * PROD_W'(w_coef);

  // Pending product sign-extended into the accumulator; wraps mod 2^ACC_W.
  assign w_acc_sum   = r_acc + ACC_W'(r_prod);

  assign w_final_ext = SN_W'(w_acc_sum);
  assign w_scaled    = sat_narrow(w_final_ext, SHIFT, OUT_W, SAT_EN);
  assign w_dout_next = w_scaled[OUT_W-1:0];
  assign w_sat_next  = w_scaled[SN_W];

  // Upper bits of the helper result are discarded by design; the clip flag is
  // only consumed in the saturating build.
  assign w_unused = ^{w_scaled[SN_W-1:OUT_W], w_sat_next};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (ce) begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_xfer)               w_next_state = ACCUM;
      ACCUM:   if (w_xfer && w_last)     w_next_state = DRAIN;
      DRAIN:                             w_next_state = HOLD;
      HOLD:    if (dout_ready)           w_next_state = IDLE;
      default:                           w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    din_ready = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE:  begin
        din_ready = 1'b1;
      end
      ACCUM: begin
        din_ready = 1'b1;
        busy      = 1'b1;
      end
      // The final product is still being folded in, so the result is not done.
      DRAIN: begin
        busy      = 1'b1;
      end
      default: begin
        din_ready = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tap        <= '0;
      r_prod       <= '0;
      r_acc        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (ce) begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_prod <= w_prod_next;
            r_tap  <= TAP_W'(1);
          end
        end
        ACCUM: begin
          // Each accept folds the previous product in exactly once; idle
          // cycles between samples leave r_prod pending.
          if (w_xfer) begin
            r_prod <= w_prod_next;
            r_acc  <= w_acc_sum;
            r_tap  <= r_tap + TAP_W'(1);
          end
        end
        DRAIN: begin
          r_dout       <= w_dout_next;
          r_dout_valid <= 1'b1;
          r_acc        <= '0;
        end
        HOLD: begin
          if (dout_ready) begin
            r_dout_valid <= 1'b0;
            r_tap        <= '0;
          end
        end
        default: begin
          r_dout_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PADD_MAC_SAT_EN
  logic r_sat;

  // Clip flag travels with the result it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sat <= 1'b0;
    end else if (ce && (r_state == DRAIN)) begin
      r_sat <= w_sat_next;
    end
  end

  assign sat = r_sat;
`endif

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule
